// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - code-breaking game turn controller; define FIXED_SECRET_EN to always use LFSR_SEED as the secret
`timescale 1ns/1ps
module game_sequencer #(
    parameter int          MAX_TURNS = 8,
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       mode_sw,
    output logic [2:0] guess3,
    output logic [2:0] guess2,
    output logic [2:0] guess1,
    output logic [2:0] guess0,
    output logic [1:0] cursor,
    output logic       store,
    output logic       hist_clear,
    output logic       hist_mode,
    output logic       hist_up,
    output logic       hist_down,
    output logic [2:0] black,
    output logic [2:0] white,
    output logic       score_valid,
    output logic [3:0] turn,
    output logic       won,
    output logic       lost,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_STORE,
        S_SCORE,
        S_RESULT,
        S_BROWSE,
        S_WON,
        S_LOST
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     lfsr_q;
    logic [11:0]     secret_src;

    // Digit arrays: element 3 is the leftmost digit (bits 11:9).
    logic [3:0][2:0] secret_q, secret_d;
    logic [3:0][2:0] guess_q, guess_d;

    logic [1:0]      cursor_d;
    logic [3:0]      step_q, step_d;
    logic [2:0]      black_acc_q, black_acc_d;
    logic [2:0]      match_acc_q, match_acc_d;
    logic [2:0]      black_d, white_d;
    logic [3:0]      turn_d;
    logic            store_d, hist_clear_d, hist_mode_d, hist_up_d, hist_down_d;
    logic            score_valid_d, won_d, lost_d, busy_d;

    logic [2:0]      colour;
    logic [2:0]      cnt_guess, cnt_secret, colour_min;
    logic [2:0]      match_sum;
    logic            digit_hit;

    assign guess3 = guess_q[3];
    assign guess2 = guess_q[2];
    assign guess1 = guess_q[1];
    assign guess0 = guess_q[0];

`ifdef FIXED_SECRET_EN
    assign secret_src = LFSR_SEED;
`else
    assign secret_src = lfsr_q;
`endif

    // Free-running Galois LFSR for x^12+x^6+x^4+x+1 (feedback taps 0x053).
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[10:0], 1'b0} ^ (lfsr_q[11] ? 12'h053 : 12'h000);
        end
    end

    // Per-step scoring terms: exact hit for steps 0-3, colour overlap for steps 4-11.
    always_comb begin
        colour     = step_q[2:0] - 3'd4;
        cnt_guess  = 3'd0;
        cnt_secret = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (guess_q[i] == colour) begin
                cnt_guess = cnt_guess + 3'd1;
            end
            if (secret_q[i] == colour) begin
                cnt_secret = cnt_secret + 3'd1;
            end
        end
        colour_min = (cnt_guess < cnt_secret) ? cnt_guess : cnt_secret;
        match_sum  = match_acc_q + colour_min;
        digit_hit  = (guess_q[step_q[1:0]] == secret_q[step_q[1:0]]);
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d       = state_q;
        secret_d      = secret_q;
        guess_d       = guess_q;
        cursor_d      = cursor;
        step_d        = step_q;
        black_acc_d   = black_acc_q;
        match_acc_d   = match_acc_q;
        black_d       = black;
        white_d       = white;
        turn_d        = turn;
        hist_clear_d  = 1'b0;
        hist_up_d     = 1'b0;
        hist_down_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_enter) begin
                    state_d      = S_ENTRY;
                    secret_d     = secret_src;
                    guess_d      = '0;
                    cursor_d     = 2'd0;
                    turn_d       = 4'd0;
                    hist_clear_d = 1'b1;
                end
            end
            S_ENTRY: begin
                if (btn_enter) begin
                    state_d     = S_STORE;
                    step_d      = 4'd0;
                    black_acc_d = 3'd0;
                    match_acc_d = 3'd0;
                    black_d     = 3'd0;
                    white_d     = 3'd0;
                end else if (mode_sw && (turn != 4'd0)) begin
                    state_d = S_BROWSE;
                end else if (btn_left) begin
                    if (cursor != 2'd3) begin
                        cursor_d = cursor + 2'd1;
                    end
                end else if (btn_right) begin
                    if (cursor != 2'd0) begin
                        cursor_d = cursor - 2'd1;
                    end
                end else if (btn_up) begin
                    guess_d[cursor] = guess_q[cursor] + 3'd1;
                end else if (btn_down) begin
                    guess_d[cursor] = guess_q[cursor] - 3'd1;
                end
            end
            S_STORE: begin
                state_d = S_SCORE;
                step_d  = 4'd0;
            end
            S_SCORE: begin
                step_d = step_q + 4'd1;
                if (step_q < 4'd4) begin
                    if (digit_hit) begin
                        black_acc_d = black_acc_q + 3'd1;
                    end
                end else begin
                    match_acc_d = match_sum;
                end
                if (step_q == 4'd11) begin
                    // Exact hits are complete by step 3; white is overlap minus exact hits.
                    state_d = S_RESULT;
                    black_d = black_acc_q;
                    white_d = match_sum - black_acc_q;
                    turn_d  = turn + 4'd1;
                end
            end
            S_RESULT: begin
                if (black == 3'd4) begin
                    state_d = S_WON;
                end else if (turn == 4'(MAX_TURNS)) begin
                    state_d = S_LOST;
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_BROWSE: begin
                if (!mode_sw) begin
                    state_d = S_ENTRY;
                end else begin
                    hist_up_d   = btn_up;
                    hist_down_d = btn_down;
                end
            end
            S_WON, S_LOST: begin
                if (btn_enter) begin
                    state_d = S_IDLE;
                end else if (mode_sw) begin
                    hist_up_d   = btn_up;
                    hist_down_d = btn_down;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        store_d       = (state_d == S_STORE);
        busy_d        = (state_d == S_STORE) || (state_d == S_SCORE);
        score_valid_d = (state_d == S_RESULT);
        won_d         = (state_d == S_WON);
        lost_d        = (state_d == S_LOST);
        hist_mode_d   = (state_d == S_BROWSE) ||
                        (((state_d == S_WON) || (state_d == S_LOST)) && mode_sw);
    end

    // State and output registers; reset overrides everything, including a scoring pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            cursor      <= 2'd0;
            step_q      <= 4'd0;
            black_acc_q <= 3'd0;
            match_acc_q <= 3'd0;
            black       <= 3'd0;
            white       <= 3'd0;
            turn        <= 4'd0;
            store       <= 1'b0;
            hist_clear  <= 1'b0;
            hist_mode   <= 1'b0;
            hist_up     <= 1'b0;
            hist_down   <= 1'b0;
            score_valid <= 1'b0;
            won         <= 1'b0;
            lost        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            cursor      <= cursor_d;
            step_q      <= step_d;
            black_acc_q <= black_acc_d;
            match_acc_q <= match_acc_d;
            black       <= black_d;
            white       <= white_d;
            turn        <= turn_d;
            store       <= store_d;
            hist_clear  <= hist_clear_d;
            hist_mode   <= hist_mode_d;
            hist_up     <= hist_up_d;
            hist_down   <= hist_down_d;
            score_valid <= score_valid_d;
            won         <= won_d;
            lost        <= lost_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int          MAX_T = 8;
    localparam logic [11:0] SEED  = 12'o1234;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_enter = 1'b0;
    logic       mode_sw = 1'b0;
    logic [2:0] guess3, guess2, guess1, guess0;
    logic [1:0] cursor;
    logic       store, hist_clear, hist_mode, hist_up, hist_down;
    logic [2:0] black, white;
    logic       score_valid;
    logic [3:0] turn;
    logic       won, lost, busy;

    game_sequencer #(.MAX_TURNS(MAX_T), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_enter(btn_enter), .mode_sw(mode_sw),
        .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
        .cursor(cursor), .store(store), .hist_clear(hist_clear),
        .hist_mode(hist_mode), .hist_up(hist_up), .hist_down(hist_down),
        .black(black), .white(white), .score_valid(score_valid),
        .turn(turn), .won(won), .lost(lost), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_lfsr = 0;
    int sec[4];
    int g[4];
    int cur = 0;
    int trn = 0;
    bit m_won = 1'b0;
    bit m_lost = 1'b0;

    typedef struct {
        int btn;
        int cur;
        int gw;
    } vec_t;
    vec_t tbl[19];

    // Multiply by x modulo the generator polynomial.
    function automatic int lfsr_next(input int v);
        int r;
        r = v * 2;
        if (r >= 4096) r = r ^ 'h1053;
        return r;
    endfunction

    always @(posedge clk) m_lfsr <= reset ? int'(SEED) : lfsr_next(m_lfsr);

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int dut_guess();
        return int'({guess3, guess2, guess1, guess0});
    endfunction

    function automatic int model_guess();
        return g[3] * 512 + g[2] * 64 + g[1] * 8 + g[0];
    endfunction

    task automatic check_guess(input string name);
        chk({name, " cursor"}, int'(cursor), cur);
        chk({name, " guess"}, dut_guess(), model_guess());
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " guess"}, dut_guess(), 0);
        chk({name, " cursor"}, int'(cursor), 0);
        chk({name, " flags"}, int'({store, hist_clear, hist_mode, hist_up, hist_down,
                                    score_valid, won, lost, busy}), 0);
        chk({name, " black"}, int'(black), 0);
        chk({name, " white"}, int'(white), 0);
        chk({name, " turn"}, int'(turn), 0);
    endtask

    function automatic int ref_black(input int a[4], input int s[4]);
        int n = 0;
        for (int i = 0; i < 4; i++) if (a[i] == s[i]) n++;
        return n;
    endfunction

    function automatic int ref_white(input int a[4], input int s[4]);
        int m = 0;
        for (int c = 0; c < 8; c++) begin
            int ca = 0;
            int cs = 0;
            for (int i = 0; i < 4; i++) begin
                if (a[i] == c) ca++;
                if (s[i] == c) cs++;
            end
            m += (ca < cs) ? ca : cs;
        end
        return m - ref_black(a, s);
    endfunction

    // 1 left, 2 right, 3 up, 4 down, 5 enter; returns at the falling edge after the sampling edge.
    task automatic press(input int b);
        case (b)
            1: btn_left = 1'b1;
            2: btn_right = 1'b1;
            3: btn_up = 1'b1;
            4: btn_down = 1'b1;
            5: btn_enter = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_enter = 1'b0;
    endtask

    task automatic model_edit(input int b);
        case (b)
            1: if (cur < 3) cur++;
            2: if (cur > 0) cur--;
            3: g[cur] = (g[cur] + 1) % 8;
            4: g[cur] = (g[cur] + 7) % 8;
            default: ;
        endcase
    endtask

    task automatic edit_to(input int t[4]);
        for (int i = 0; i < 4; i++) begin
            while (cur < i) begin press(1); model_edit(1); check_guess("edit"); end
            while (cur > i) begin press(2); model_edit(2); check_guess("edit"); end
            while (g[i] != t[i]) begin
                int b;
                b = (((t[i] - g[i] + 8) % 8) <= 4) ? 3 : 4;
                press(b);
                model_edit(b);
                check_guess("edit");
            end
        end
    endtask

    task automatic new_game();
        int v;
`ifdef FIXED_SECRET_EN
        v = int'(SEED);
`else
        v = m_lfsr;
`endif
        for (int i = 0; i < 4; i++) sec[i] = (v >> (3 * i)) & 7;
        press(5);
        for (int i = 0; i < 4; i++) g[i] = 0;
        cur = 0;
        trn = 0;
        m_won = 1'b0;
        m_lost = 1'b0;
        chk("new hist_clear", int'(hist_clear), 1);
        check_guess("new");
        chk("new turn", int'(turn), 0);
        chk("new flags", int'({won, lost, busy, store}), 0);
        @(negedge clk);
        chk("new hist_clear pulse", int'(hist_clear), 0);
    endtask

    // Submit the current guess and check the 12-cycle scoring pass and its result.
    task automatic submit(input int fb, input int fw);
        int eb;
        int ew;
        eb = ref_black(g, sec);
        ew = ref_white(g, sec);
        press(5);
        chk("store N+1", int'(store), 1);
        chk("busy N+1", int'(busy), 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("score busy", int'(busy), 1);
            chk("score store", int'(store), 0);
            chk("score valid early", int'(score_valid), 0);
            btn_up = (k == 3);
        end
        btn_up = 1'b0;
        @(negedge clk);
        chk("score_valid N+14", int'(score_valid), 1);
        chk("result busy", int'(busy), 0);
        chk("result black", int'(black), eb);
        chk("result white", int'(white), ew);
        chk("result turn", int'(turn), trn + 1);
        chk("result won early", int'(won), 0);
        if (fb >= 0) begin
            chk("plan black", int'(black), fb);
            chk("plan white", int'(white), fw);
        end
        trn++;
        m_won = (eb == 4);
        m_lost = !m_won && (trn == MAX_T);
        @(negedge clk);
        chk("after valid", int'(score_valid), 0);
        chk("after won", int'(won), int'(m_won));
        chk("after lost", int'(lost), int'(m_lost));
        chk("hold black", int'(black), eb);
        chk("hold white", int'(white), ew);
        chk("hold turn", int'(turn), trn);
        check_guess("after score");
    endtask

    task automatic end_game();
        press(5);
        chk("end won", int'(won), 0);
        chk("end lost", int'(lost), 0);
        chk("end hist_mode", int'(hist_mode), 0);
        m_won = 1'b0;
        m_lost = 1'b0;
    endtask

    initial begin
        int t[4];
        int gl[3][4];
        int fb[3];
        int fw[3];
        int d;

        // Editing vectors from 0,0,0,0 to 4,3,2,1 with saturation and wrap cases.
        tbl[0]  = '{2, 0, 12'o0000};
        tbl[1]  = '{4, 0, 12'o0007};
        tbl[2]  = '{3, 0, 12'o0000};
        tbl[3]  = '{3, 0, 12'o0001};
        tbl[4]  = '{1, 1, 12'o0001};
        tbl[5]  = '{3, 1, 12'o0011};
        tbl[6]  = '{3, 1, 12'o0021};
        tbl[7]  = '{1, 2, 12'o0021};
        tbl[8]  = '{3, 2, 12'o0121};
        tbl[9]  = '{3, 2, 12'o0221};
        tbl[10] = '{3, 2, 12'o0321};
        tbl[11] = '{1, 3, 12'o0321};
        tbl[12] = '{3, 3, 12'o1321};
        tbl[13] = '{3, 3, 12'o2321};
        tbl[14] = '{3, 3, 12'o3321};
        tbl[15] = '{3, 3, 12'o4321};
        tbl[16] = '{1, 3, 12'o4321};
        tbl[17] = '{2, 2, 12'o4321};
        tbl[18] = '{1, 3, 12'o4321};

        gl[0] = '{3, 4, 2, 1};
        gl[1] = '{1, 1, 1, 1};
        gl[2] = '{0, 7, 6, 5};
        fb = '{2, 1, 0};
        fw = '{2, 0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        press(1);
        chk("idle left cursor", int'(cursor), 0);
        chk("idle left clear", int'(hist_clear), 0);

        // Game 1: test-plan guesses, then the secret.
        new_game();
        mode_sw = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("browse at turn0", int'(hist_mode), 0);
        end
        mode_sw = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            press(tbl[i].btn);
            model_edit(tbl[i].btn);
            chk($sformatf("tbl%0d cursor", i), int'(cursor), tbl[i].cur);
            chk($sformatf("tbl%0d guess", i), dut_guess(), tbl[i].gw);
        end
`ifdef FIXED_SECRET_EN
        submit(0, 4);
`else
        submit(-1, -1);
`endif

        if (!m_won) begin
            mode_sw = 1'b1;
            @(negedge clk);
            chk("browse hist_mode", int'(hist_mode), 1);
            press(3);
            chk("browse hist_up", int'(hist_up), 1);
            check_guess("browse up ignored");
            @(negedge clk);
            chk("browse hist_up pulse", int'(hist_up), 0);
            press(5);
            chk("browse enter store", int'(store), 0);
            chk("browse enter busy", int'(busy), 0);
            chk("browse enter mode", int'(hist_mode), 1);
            press(1);
            check_guess("browse left ignored");
            mode_sw = 1'b0;
            @(negedge clk);
            chk("browse exit", int'(hist_mode), 0);
        end

        for (int k = 0; k < 3; k++) begin
            if (!m_won && !m_lost) begin
                edit_to(gl[k]);
`ifdef FIXED_SECRET_EN
                submit(fb[k], fw[k]);
`else
                submit(-1, -1);
`endif
            end
        end
        if (!m_won && !m_lost) begin
            edit_to(sec);
            submit(-1, -1);
        end
        chk("game1 won", int'(won), 1);
        end_game();

        // Game 2: win on the first guess; history browse while won.
        new_game();
        edit_to(sec);
`ifdef FIXED_SECRET_EN
        submit(4, 0);
`else
        submit(-1, -1);
`endif
        chk("game2 won", int'(won), 1);
        chk("game2 turn", int'(turn), 1);
        mode_sw = 1'b1;
        @(negedge clk);
        chk("won hist_mode", int'(hist_mode), 1);
        press(4);
        chk("won hist_down", int'(hist_down), 1);
        @(negedge clk);
        chk("won hist_down pulse", int'(hist_down), 0);
        mode_sw = 1'b0;
        @(negedge clk);
        chk("won hist_mode off", int'(hist_mode), 0);
        end_game();

        // Game 3: MAX_TURNS non-winning guesses.
        new_game();
        d = (sec[0] == 0 && sec[1] == 0 && sec[2] == 0 && sec[3] == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) t[i] = d;
        edit_to(t);
        for (int k = 0; k < MAX_T; k++) begin
            if (!m_won && !m_lost) submit(-1, -1);
        end
        chk("game3 lost", int'(lost), 1);
        chk("game3 turn", int'(turn), MAX_T);
        end_game();

        // Randomized games against the model.
        for (int gm = 0; gm < 2; gm++) begin
            new_game();
            while (!m_won && !m_lost) begin
                for (int i = 0; i < 4; i++) t[i] = int'($urandom_range(0, 7));
                edit_to(t);
                submit(-1, -1);
            end
            end_game();
        end

        // Reset during the 5th scoring cycle.
        new_game();
        press(5);
        chk("rst store", int'(store), 1);
        repeat (5) @(negedge clk);
        chk("rst in score", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid-score reset");
        reset = 1'b0;
        @(negedge clk);
        new_game();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level turn controller for the code-breaking game. It owns the secret code and the guess-entry editor, and issues store, clear and browse strobes to the guess-history block. It scores each submitted guess over a fixed 12-cycle sequence and decides win or loss. It sits between the debounced button and switch inputs and the history/feedback datapath.

Parameters:
MAX_TURNS, 8, number of guesses allowed per game (1..8)
LFSR_SEED, 12'hACE, reset value of the secret-generator LFSR; must be nonzero

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_left, btn_right, btn_up, btn_down, btn_enter  input  1 each  single-cycle debounced button pulses
mode_sw  input  1  0 = guess mode, 1 = history browse
guess3, guess2, guess1, guess0  output  3 each  current guess digits, drive the history guess inputs
cursor  output  2  index of the digit being edited (3 = guess3)
store  output  1  one-cycle strobe: commit guess to history
hist_clear  output  1  one-cycle strobe: clear history at new game
hist_mode  output  1  history browse enable
hist_up, hist_down  output  1 each  forwarded browse pulses
black, white  output  3 each  score of the last guess
score_valid  output  1  one-cycle pulse when black/white update
turn  output  4  guesses completed this game
won, lost, busy  output  1 each  status flags

Behaviour:
- Reset: state IDLE; every output 0; LFSR = LFSR_SEED. Reset wins over all other inputs in any state, including mid-SCORE.
- LFSR: 12-bit Galois, polynomial x^12+x^6+x^4+x+1, advances every cycle outside reset.
- All outputs are registered. Strobes are high for exactly one cycle.
- IDLE: on btn_enter, latch secret = LFSR (secret3 = bits 11:9 … secret0 = bits 2:0); clear guess digits, cursor and turn to 0; pulse hist_clear; go to ENTRY.
- ENTRY: one button acts per cycle, priority enter > left > right > up > down.
  - left: cursor+1, saturates at 3. right: cursor-1, saturates at 0.
  - up/down: selected digit +1/-1 modulo 8 (7 -> 0, 0 -> 7).
  - enter: go to STORE.
  - mode_sw=1 with turn>0: go to BROWSE. With turn=0, mode_sw is ignored.
- STORE: store=1, busy=1 for one cycle; then SCORE.
- SCORE: busy=1 for 12 cycles driven by a 4-bit step counter.
  - Steps 0-3: black += (guess[i]==secret[i]).
  - Steps 4-11: colour c = step-4; m += min(count of c in guess, count of c in secret).
  - After step 11: white = m - black. Width: m ≤ 4, so 3 bits suffice.
- RESULT: one cycle.
  - score_valid=1; turn += 1.
  - If black==4: go to WON.
  - Else if the new turn == MAX_TURNS: go to LOST.
  - Else: go to ENTRY, keeping the guess digits and cursor.
- black and white hold their value until the next STORE.
- Latency: enter sampled at edge N gives store during cycle N+1, SCORE during N+2..N+13, score_valid during N+14.
- BROWSE: hist_mode=1. btn_up/btn_down are forwarded as hist_up/hist_down the next cycle. Enter, left and right are ignored. mode_sw=0 returns to ENTRY.
- WON/LOST: won or lost held at 1. hist_mode follows mode_sw, and up/down are forwarded while it is set. btn_enter clears won/lost and goes to IDLE.
- Buttons arriving during STORE, SCORE or RESULT are dropped.

Optional Feature:
FIXED_SECRET_EN
- Defined: the secret latched in IDLE is always LFSR_SEED, giving deterministic games for verification and demos.
- Undefined: the secret is the free-running LFSR value at the moment of the IDLE enter press.

Test Plan:
1. FIXED_SECRET_EN, LFSR_SEED=12'o1234 (secret 1,2,3,4); reset; enter -> hist_clear high exactly one cycle, guess=0,0,0,0, cursor=0, turn=0, all flags 0.
2. Enter guess 4,3,2,1 using left/up, including a down press at 0 that wraps to 7 and is then corrected; submit at edge N -> store at N+1, score_valid at N+14 with black=0, white=4, turn=1. Then guess 1,2,4,3 -> black=2, white=2.
3. Guess 1,1,1,1 -> black=1, white=0. Guess 5,6,7,0 -> black=0, white=0.
4. Guess 1,2,3,4 -> black=4, won=1 from the cycle after score_valid, turn=1; enter -> IDLE, won=0.
5. MAX_TURNS=8, eight guesses of 0,0,0,0 -> lost=1 after the 8th score_valid, turn=8. Ninth enter -> IDLE.
6. mode_sw=1 at turn=0 -> hist_mode stays 0. After one turn, mode_sw=1 -> hist_mode=1; btn_up -> hist_up one cycle; enter has no effect. Separately, assert reset in the 5th SCORE cycle -> next cycle IDLE with every output 0.
